// File: rtl/add_seq_ctrl.sv
// Sequential WIDTH-bit adder: one SLICE-bit ripple slice per clock, LSB slice first,
// with valid/ready handshakes on both sides. Optional macro ADD_SEQ_OVF_EN adds the ovf port.
module add_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   s_r;
    logic               cout_r;
    logic               out_valid_r;
    logic [SLICE:0]     slice_sum_s;
    logic               last_slice_s;
`ifdef ADD_SEQ_OVF_EN
    logic               ovf_r;
`endif

    // The single shared slice adder; bit SLICE is the slice carry out.
    always_comb begin
        slice_sum_s  = {1'b0, a_r[idx_r*SLICE +: SLICE]}
                     + {1'b0, b_r[idx_r*SLICE +: SLICE]}
                     + {{SLICE{1'b0}}, carry_r};
        last_slice_s = (idx_r == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, slice write-back and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            s_r         <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx_r   <= '0;
                    end
                end
                ST_RUN: begin
                    s_r[idx_r*SLICE +: SLICE] <= slice_sum_s[SLICE-1:0];
                    carry_r                   <= slice_sum_s[SLICE];
                    if (last_slice_s) begin
                        cout_r <= slice_sum_s[SLICE];
`ifdef ADD_SEQ_OVF_EN
                        // Carry into the sign bit recovered from the sign-bit sum.
                        ovf_r  <= (a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ slice_sum_s[SLICE-1])
                                  ^ slice_sum_s[SLICE];
`endif
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // in_ready is a pure state decode, held low while reset is asserted.
    assign in_ready  = rst_n & (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign cout      = cout_r;
`ifdef ADD_SEQ_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl (WIDTH=32, SLICE=8, N=4).
module tb_add_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
`ifdef ADD_SEQ_OVF_EN
    logic        ovf;
`endif

    int checks;
    int errors;

    add_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef ADD_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Issue one request, wait for the result, optionally stall in DONE, then retire it.
    task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [31:0] exp_s, input logic exp_c,
                         input logic exp_o, input int hold);
        int wait_cnt;
        int lat;
        wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
        cin      = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({tag, ".latency"}, 64'(lat), 64'd4);
        check_eq({tag, ".s"}, 64'(s), 64'(exp_s));
        check_eq({tag, ".cout"}, 64'(cout), 64'(exp_c));
`ifdef ADD_SEQ_OVF_EN
        check_eq({tag, ".ovf"}, 64'(ovf), 64'(exp_o));
`else
        if (exp_o) begin
        end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            a         = 32'h5555_5555 + 32'(i);
            b         = 32'hAAAA_AAAA;
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, ".hold_s"}, 64'(s), 64'(exp_s));
            check_eq({tag, ".hold_cout"}, 64'(cout), 64'(exp_c));
            check_eq({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ".retire_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".retire_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        cin       = 1'b0;

        // 1. Reset values, then in_ready on the first cycle out of reset.
        #12;
        check_eq("rst.out_valid", 64'(out_valid), 64'd0);
        check_eq("rst.in_ready", 64'(in_ready), 64'd0);
        check_eq("rst.s", 64'(s), 64'd0);
        check_eq("rst.cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst.release_in_ready", 64'(in_ready), 64'd1);

        // 2. Full carry ripple through all slices.
        do_op("ripple", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);

        // 3. Carry in used, then back-to-back at earliest in_ready.
        do_op("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 0);
        do_op("msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0);

        // 4. Backpressure: 5 stalled cycles in DONE with a competing request.
        do_op("bp", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0, 5);
        @(posedge clk);
        @(negedge clk);
        check_eq("bp.no_accept", 64'(out_valid), 64'd0);
        check_eq("bp.idle_ready", 64'(in_ready), 64'd1);

        // 5. Abort in the 2nd RUN cycle; slice 0 already written must be cleared.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h0000_00FF;
        b        = 32'h0000_00FF;
        cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort.out_valid", 64'(out_valid), 64'd0);
        check_eq("abort.in_ready", 64'(in_ready), 64'd0);
        check_eq("abort.s", 64'(s), 64'd0);
        check_eq("abort.cout", 64'(cout), 64'd0);
        #2;
        rst_n = 1'b1;
        do_op("post_abort", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0);

`ifdef ADD_SEQ_OVF_EN
        // 6. Signed overflow flag.
        do_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        do_op("ovf_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
